// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 7-segment scan with frame-synchronous loading, PWM brightness and dead-time blanking
module seg_scan_driver #(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 4096,
    parameter int BRIGHT_W   = 3,
    parameter int DEAD_TICKS = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   VALUE,
    input  logic                  LOAD,
    input  logic [BRIGHT_W-1:0]   BRIGHT,
    input  logic                  LZB,
    output logic                  PENDING,
    output logic [DIGITS-1:0]     DS_EN,
    output logic [6:0]            DS_SEG
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam logic [1:0] BLANK = 2'd0;
    localparam logic [1:0] ON    = 2'd1;
    localparam logic [1:0] OFF   = 2'd2;
    localparam logic [6:0] SEG_LUT [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    logic [PW-1:0]         presc;
    logic [BRIGHT_W-1:0]   sub, sub_n, bright_q, bright_n;
    logic [IW-1:0]         idx, idx_n;
    logic [1:0]            state, state_n;
    logic [4*DIGITS-1:0]   shadow, disp, disp_n;
    logic [DIGITS-1:0]     lz;
    logic [3:0]            nib;
    logic                  tick, slot_end, frame_end, lit;

    // Next-state view of the scan: what the counters, display and FSM become on this edge
    always_comb begin
        tick      = presc == PW'(SCAN_DIV - 1);
        slot_end  = tick && sub == '1;
        frame_end = slot_end && idx == IW'(DIGITS - 1);
        sub_n     = tick ? sub + BRIGHT_W'(1) : sub;
        idx_n     = slot_end ? (idx == IW'(DIGITS - 1) ? '0 : idx + IW'(1)) : idx;
        bright_n  = slot_end ? BRIGHT : bright_q;
        disp_n    = frame_end && PENDING ? shadow : disp;
        state_n   = !tick ? state :
                    sub_n < BRIGHT_W'(DEAD_TICKS) ? BLANK :
                    sub_n < bright_n ? ON : OFF;
        lz = '0;
        lz[DIGITS-1] = disp_n[4*DIGITS-1 -: 4] == 4'd0;
        for (int i = DIGITS - 2; i >= 0; i--) lz[i] = lz[i+1] && disp_n[4*i +: 4] == 4'd0;
        nib = disp_n[idx_n*4 +: 4];
        lit = state_n == ON && !(LZB && idx_n != '0 && lz[idx_n]);
    end

    // Scan counters, frame-boundary display swap, shadow loading and registered pin drive
    always_ff @(posedge CLK) begin
        if (RST) begin
            presc    <= '0;
            sub      <= '0;
            idx      <= '0;
            bright_q <= '0;
            state    <= BLANK;
            shadow   <= '0;
            disp     <= '0;
            PENDING  <= 1'b0;
            DS_EN    <= '1;
            DS_SEG   <= '0;
        end else begin
            presc    <= tick ? '0 : presc + PW'(1);
            sub      <= sub_n;
            idx      <= idx_n;
            bright_q <= bright_n;
            state    <= state_n;
            disp     <= disp_n;
            if (LOAD) begin
                shadow  <= VALUE;
                PENDING <= 1'b1;
            end else if (frame_end) begin
                PENDING <= 1'b0;
            end
            DS_EN  <= lit ? ~(DIGITS'(1) << idx_n) : '1;
            DS_SEG <= lit ? SEG_LUT[nib] : '0;
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: randomized and directed checks of seg_scan_driver against a cycle-count reference model
module tb_seg_scan_driver;
    localparam int SLOT = 32;
    localparam int FRAME = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        lzb = 1'b0;
    logic [15:0] value = '0;
    logic [2:0]  bright = '0;
    logic        pending;
    logic [3:0]  ds_en;
    logic [6:0]  ds_seg;

    int n_pass = 0;
    int n_total = 0;
    int n = 0;
    int h, l;

    logic [15:0] m_sh, m_disp;
    logic        m_pend;
    int          m_bq, mt, msub, midx;
    logic        mon;
    logic [3:0]  x_en;
    logic [6:0]  x_seg;

    logic [6:0] lut [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .BRIGHT_W(3), .DEAD_TICKS(1)) dut (
        .CLK(clk), .RST(rst), .VALUE(value), .LOAD(load), .BRIGHT(bright),
        .LZB(lzb), .PENDING(pending), .DS_EN(ds_en), .DS_SEG(ds_seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Reference: position in the scan follows from the number of edges since reset
    always @(posedge clk) begin
        if (rst) begin
            n = 0; m_sh = '0; m_disp = '0; m_pend = 1'b0; m_bq = 0;
        end else begin
            n++;
            if (n % SLOT == 0) m_bq = bright;
            if (n % FRAME == 0 && m_pend) m_disp = m_sh;
            if (load) begin
                m_sh = value; m_pend = 1'b1;
            end else if (n % FRAME == 0) begin
                m_pend = 1'b0;
            end
        end
        mt = n / 4;
        msub = mt % 8;
        midx = (mt / 8) % 4;
        mon = !rst && msub >= 1 && msub < m_bq && !(lzb && midx > 0 && (m_disp >> (4 * midx)) == 0);
        x_en = mon ? ~(4'b0001 << midx) : 4'hF;
        x_seg = mon ? lut[m_disp[4*midx +: 4]] : 7'd0;
    end

    // Continuous comparison and scan properties, away from the active edge
    always @(negedge clk) begin
        check("ds_en", ds_en, x_en);
        check("ds_seg", ds_seg, x_seg);
        check("pending", pending, m_pend);
        check("one_cold", $countones(~ds_en) <= 1, 1);
        if (!rst && n % SLOT < 4) check("dead_tick", ds_en, 4'hF);
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic to_frame();
        for (int i = 0; i < 2 * FRAME && n % FRAME != 0; i++) @(negedge clk);
    endtask

    task automatic next_frame();
        @(negedge clk);
        to_frame();
    endtask

    task automatic count_frame(input logic [3:0] en, input logic [6:0] seg, output int hit, output int lit);
        hit = 0; lit = 0;
        repeat (FRAME) begin
            if (ds_en == en && ds_seg == seg) hit++;
            if (ds_en != 4'hF) lit++;
            @(negedge clk);
        end
    endtask

    initial begin
        cyc(2);
        check("rst_en", ds_en, 4'hF);
        check("rst_seg", ds_seg, 0);
        check("rst_pend", pending, 0);
        rst = 1'b0;
        value = 16'h1234; bright = 7; load = 1'b1;
        cyc(1);
        load = 1'b0;
        check("pend_set", pending, 1);
        to_frame();
        check("pend_clr", pending, 0);
        count_frame(4'b1110, 7'b0110011, h, l);
        check("d0_four", h, 24);
        count_frame(4'b0111, 7'b0110000, h, l);
        check("d3_one", h, 24);
        bright = 0;
        next_frame();
        count_frame(4'hF, 7'd0, h, l);
        check("b0_dark", l, 0);
        bright = 1;
        next_frame();
        count_frame(4'hF, 7'd0, h, l);
        check("b1_dark", l, 0);
        bright = 4;
        next_frame();
        count_frame(4'b1110, 7'b0110011, h, l);
        check("b4_on", h, 12);
        check("b4_lit", l, 48);
        bright = 7;
        next_frame();
        cyc(40);
        bright = 2;
        cyc(1);
        to_frame();
        bright = 7;
        value = 16'hAAAA; load = 1'b1;
        cyc(1);
        load = 1'b0;
        cyc(10);
        value = 16'h5555; load = 1'b1;
        cyc(1);
        load = 1'b0;
        to_frame();
        count_frame(4'b1110, 7'b1011011, h, l);
        check("last_wins", h, 24);
        value = 16'hAAAA; load = 1'b1;
        cyc(1);
        load = 1'b0;
        for (int i = 0; i < 2 * FRAME && n % FRAME != FRAME - 1; i++) cyc(1);
        value = 16'h5555; load = 1'b1;
        cyc(1);
        load = 1'b0;
        check("pend_keep", pending, 1);
        count_frame(4'b1110, 7'b1110111, h, l);
        check("bnd_old", h, 24);
        check("pend_clr2", pending, 0);
        count_frame(4'b1110, 7'b1011011, h, l);
        check("bnd_new", h, 24);
        lzb = 1'b1; value = 16'h0070; load = 1'b1;
        cyc(1);
        load = 1'b0;
        to_frame();
        count_frame(4'b1101, 7'b1110000, h, l);
        check("lz_d1", h, 24);
        check("lz_lit", l, 48);
        value = 16'h0000; load = 1'b1;
        cyc(1);
        load = 1'b0;
        to_frame();
        count_frame(4'b1110, 7'b1111110, h, l);
        check("lz0_d0", h, 24);
        check("lz0_lit", l, 24);
        cyc(10);
        check("pre_rst_on", ds_en, 4'b1110);
        rst = 1'b1;
        cyc(1);
        check("rst_mid_en", ds_en, 4'hF);
        check("rst_mid_seg", ds_seg, 0);
        check("rst_mid_pend", pending, 0);
        rst = 1'b0;
        repeat (10 * FRAME) begin
            load = $urandom_range(0, 15) == 0;
            value = $urandom_range(0, 2) == 0 ? 16'($urandom & 32'h00FF) : 16'($urandom);
            bright = 3'($urandom);
            lzb = 1'($urandom);
            cyc(1);
        end
        load = 1'b0;
        cyc(4);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
